// File: rtl/pattern_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package pattern_det_pkg;

   localparam logic [3:0]  PATTERN_DEFAULT = 4'b1101;
   localparam int unsigned W_MIN           = 2;
   localparam int unsigned W_MAX           = 16;

   // Width needed to count 0..w inclusive.
   function automatic int unsigned fill_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/pattern_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/pattern_det.sv
// Serial pattern detector with run-time reprogrammable pattern,
// selectable overlap semantics and a saturating match counter.
module pattern_det
   import pattern_det_pkg::*;
#(
   parameter int unsigned    W       = 4,
   parameter logic [W-1:0]   PATTERN = W'(PATTERN_DEFAULT),
   parameter bit             OVERLAP = 1'b1,
   parameter int unsigned    CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             en,
   input  logic             pat_load,
   input  logic [W-1:0]     pat_in,
   input  logic             clr_cnt,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic [W-1:0]     pat
);

   localparam int unsigned FW = fill_width(W);

   if ((W < W_MIN) || (W > W_MAX)) begin : g_bad_w
      $error("pattern_det: W out of legal range");
   end

   // Only the newest W-1 bits are ever needed: the oldest bit of the
   // shift window falls out before it could take part in a compare.
   logic [W-2:0] hist;
   logic [FW-1:0] fill;
   logic [W-1:0]  nw;
   logic          hit;

   assign nw  = {hist, x};
   assign hit = en && !pat_load && (nw == pat) && (fill >= FW'(W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
         pat  <= PATTERN;
         z    <= 1'b0;
      end else if (pat_load) begin
         pat  <= pat_in;
         hist <= '0;
         fill <= '0;
         z    <= 1'b0;
      end else if (en) begin
         z <= hit;
         if (hit && !OVERLAP) begin
            hist <= '0;
            fill <= '0;
         end else begin
            hist <= nw[W-2:0];
            fill <= (fill == FW'(W)) ? fill : fill + 1'b1;
         end
      end else begin
         z <= 1'b0;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (hit),
      .cnt (match_cnt)
   );

endmodule

// File: tb/tb_pattern_det.sv
// Directed table-driven bench for pattern_det across three parameterisations.
module tb_pattern_det;

   logic       clk;
   logic       rst, x, en, pat_load, clr_cnt;
   logic [3:0] pat_in;

   logic       z1, z0, z2;
   logic [7:0] cnt1, cnt0;
   logic [1:0] cnt2;
   logic [3:0] pat1, pat0, pat2;

   int checks = 0;
   int passes = 0;

   pattern_det #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) d1 (
      .clk(clk), .rst(rst), .x(x), .en(en), .pat_load(pat_load),
      .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z1), .match_cnt(cnt1), .pat(pat1));

   pattern_det #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) d0 (
      .clk(clk), .rst(rst), .x(x), .en(en), .pat_load(pat_load),
      .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z0), .match_cnt(cnt0), .pat(pat0));

   pattern_det #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) d2 (
      .clk(clk), .rst(rst), .x(x), .en(en), .pat_load(pat_load),
      .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z2), .match_cnt(cnt2), .pat(pat2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, x, ld;
      logic [3:0] pin;
      logic       clr;
      bit         sel;   // 0: check d1/d0, 1: check d2
      int         z1, c1, z0, c0;
      logic [3:0] pat;
      int         z2, c2;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic e, logic xi, logic l, logic [3:0] pi,
                               logic c, bit s, int ez1, int ec1, int ez0, int ec0,
                               logic [3:0] ep, int ez2, int ec2);
      vec_t v;
      v.rst = r; v.en = e; v.x = xi; v.ld = l; v.pin = pi; v.clr = c; v.sel = s;
      v.z1 = ez1; v.c1 = ec1; v.z0 = ez0; v.c0 = ec0; v.pat = ep;
      v.z2 = ez2; v.c2 = ec2;
      return v;
   endfunction

   // shorthand for d1/d0 rows and d2 rows
   function automatic vec_t a(logic r, logic e, logic xi, logic l, logic [3:0] pi,
                              logic c, int ez1, int ec1, int ez0, int ec0, logic [3:0] ep);
      return mk(r, e, xi, l, pi, c, 1'b0, ez1, ec1, ez0, ec0, ep, 0, 0);
   endfunction

   function automatic vec_t b(logic r, logic e, logic xi, logic c, int ez2, int ec2);
      return mk(r, e, xi, 1'b0, 4'b0000, c, 1'b1, 0, 0, 0, 0, 4'b1111, ez2, ec2);
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
   endtask

   task automatic drive(input logic r, input logic e, input logic xi, input logic l,
                        input logic [3:0] pi, input logic c);
      @(negedge clk);
      rst = r; en = e; x = xi; pat_load = l; pat_in = pi; clr_cnt = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; x = 1'b0; pat_load = 1'b0; pat_in = '0; clr_cnt = 1'b0;

      // reset state
      vecs.push_back(a(1,0,0,0,4'h0,0, 0,0,0,0, 4'b1101));
      // stream 0,1,1,0,1,1,0,1: overlap hits at bits 5 and 8, non-overlap only at 5
      vecs.push_back(a(0,1,0,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,0,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 1,1,1,1, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,1,0,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 1,2,0,1, 4'b1101));
      // load 0110 mid-stream (en=1 ignored), then 0,1,1,0
      vecs.push_back(a(0,1,1,1,4'b0110,0, 0,2,0,1, 4'b0110));
      vecs.push_back(a(0,1,0,0,4'h0,0, 0,2,0,1, 4'b0110));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,2,0,1, 4'b0110));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,2,0,1, 4'b0110));
      vecs.push_back(a(0,1,0,0,4'h0,0, 1,3,1,2, 4'b0110));
      // reset restores default pattern; 3 bits then reset, then 1,1,0,1
      vecs.push_back(a(1,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,0,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(1,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,0,0,4'h0,0, 0,0,0,0, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 1,1,1,1, 4'b1101));
      // en gaps: 1,1,0,1 with en=0 cycles and x toggling in between
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,0,0,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,0,1,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,1,0,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,0,1,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,0,0,0,4'h0,0, 0,1,0,1, 4'b1101));
      vecs.push_back(a(0,1,1,0,4'h0,0, 1,2,1,2, 4'b1101));
      vecs.push_back(a(0,0,1,0,4'h0,0, 0,2,0,2, 4'b1101));
      // clr_cnt without a hit
      vecs.push_back(a(0,0,1,0,4'h0,1, 0,0,0,0, 4'b1101));
      // d2: CNT_W=2, pattern 1111, eight 1s then clr_cnt with a hit
      vecs.push_back(b(1,0,0,0, 0,0));
      vecs.push_back(b(0,1,1,0, 0,0));
      vecs.push_back(b(0,1,1,0, 0,0));
      vecs.push_back(b(0,1,1,0, 0,0));
      vecs.push_back(b(0,1,1,0, 1,1));
      vecs.push_back(b(0,1,1,0, 1,2));
      vecs.push_back(b(0,1,1,0, 1,3));
      vecs.push_back(b(0,1,1,0, 1,3));
      vecs.push_back(b(0,1,1,0, 1,3));
      vecs.push_back(b(0,1,1,1, 1,0));
      vecs.push_back(b(0,1,1,0, 1,1));
      vecs.push_back(b(0,0,1,0, 0,1));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].x, vecs[i].ld, vecs[i].pin, vecs[i].clr);
         if (!vecs[i].sel) begin
            chk("z_ovl",   i, int'(z1),   vecs[i].z1);
            chk("cnt_ovl", i, int'(cnt1), vecs[i].c1);
            chk("z_nov",   i, int'(z0),   vecs[i].z0);
            chk("cnt_nov", i, int'(cnt0), vecs[i].c0);
            chk("pat_ovl", i, int'(pat1), int'(vecs[i].pat));
            chk("pat_nov", i, int'(pat0), int'(vecs[i].pat));
         end else begin
            chk("z_sat",   i, int'(z2),   vecs[i].z2);
            chk("cnt_sat", i, int'(cnt2), vecs[i].c2);
            chk("pat_sat", i, int'(pat2), int'(vecs[i].pat));
         end
      end

      // all-zero pattern with constant zero input: overlap fires every cycle
      // from the 4th bit, non-overlap every 4th bit
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
      chk("pat_zero", 0, int'(pat1), 0);
      chk("cnt_clr",  0, int'(cnt1), 0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
         chk("z_zero_ovl", i, int'(z1), (i >= 3) ? 1 : 0);
         chk("z_zero_nov", i, int'(z0), (i == 3 || i == 7) ? 1 : 0);
      end
      chk("cnt_zero_ovl", 0, int'(cnt1), 5);
      chk("cnt_zero_nov", 0, int'(cnt0), 2);

      // z is a pulse: drops on the first en=0 edge
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      chk("z_drop", 0, int'(z1), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
